// File: rtl/pipe_if_id_buf.sv
// pipe_if_id_buf: two-entry skid buffer at the IF/ID boundary of the MIPS pipeline.
// Fetch may run up to two words ahead of a stalled decode stage. A flush
// discards everything buffered. An empty buffer presents a NOP bubble
// (instruction 0) to decode.
// Optional build macro: PIPE_IF_ID_PERF_EN adds the stall_cycles counter port.
`timescale 1ns/1ps

module pipe_if_id_buf #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_valid,
    output logic          if_ready,
    input  logic [DW-1:0] if_pc4,
    input  logic [DW-1:0] if_instruction,
    input  logic          flush,
    input  logic          id_ready,
    output logic          id_valid,
    output logic [DW-1:0] id_pc4,
    output logic [DW-1:0] id_instruction,
    output logic [1:0]    occupancy
`ifdef PIPE_IF_ID_PERF_EN
    ,
    output logic [31:0]   stall_cycles
`endif
);

    localparam int unsigned PW = 1;
    localparam int unsigned CW = 2;
    localparam int unsigned SW = 32;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [DW-1:0] pc4;
        logic [DW-1:0] instruction;
    } entry_t;

    entry_t         entry_q [DEPTH];
    logic [PW-1:0]  wr_q, wr_d;
    logic [PW-1:0]  rd_q, rd_d;
    logic [CW-1:0]  count_q, count_d;
    logic           push_c;
    logic           pop_c;

    // Handshake and head-word presentation, derived from registered state only
    always_comb begin
        if_ready       = (count_q != FULL);
        id_valid       = (count_q != '0);
        id_pc4         = '0;
        id_instruction = '0;
        occupancy      = count_q;
        if (id_valid) begin
            id_pc4         = entry_q[rd_q].pc4;
            id_instruction = entry_q[rd_q].instruction;
        end
    end

    assign push_c = if_valid & if_ready & ~flush;
    assign pop_c  = id_valid & id_ready & ~flush;

    // Next pointer/count; flush overrides any push or pop
    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (flush) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            if (push_c) wr_d = wr_q + PW'(1);
            if (pop_c)  rd_d = rd_q + PW'(1);
            if (push_c && !pop_c) begin
                count_d = count_q + CW'(1);
            end else if (pop_c && !push_c) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // Pointer and count registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents left stale on flush since count gates visibility
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else if (push_c) begin
            entry_q[wr_q] <= '{pc4: if_pc4, instruction: if_instruction};
        end
    end

`ifdef PIPE_IF_ID_PERF_EN
    logic [SW-1:0] stall_q, stall_d;

    // Count cycles where fetch is held off by a full buffer
    always_comb begin
        stall_d = stall_q;
        if (if_valid && !if_ready && !flush) begin
            stall_d = stall_q + SW'(1);
        end
    end

    // Stall counter register; survives flush
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_pipe_if_id_buf.sv
// tb_pipe_if_id_buf: scoreboard bench for pipe_if_id_buf.
// The reference model is a bounded FIFO queue of {pc4, instruction} words.
// The stimulus thread pushes the words it expects to be accepted. The monitor
// checks the head and handshake each cycle and pops on every consumed word.
`timescale 1ns/1ps

module tb_pipe_if_id_buf;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] ins;
    } word_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc4;
    logic [31:0] if_instruction;
    logic        flush;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_pc4;
    logic [31:0] id_instruction;
    logic [1:0]  occupancy;
`ifdef PIPE_IF_ID_PERF_EN
    logic [31:0] stall_cycles;
`endif

    word_t       exp_q[$];
    int          n_checks = 0;
    int          n_err    = 0;
    bit          mon_en   = 1'b0;
    logic [31:0] stall_exp = '0;

    pipe_if_id_buf #(.DEPTH(2), .DW(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc4         (if_pc4),
        .if_instruction (if_instruction),
        .flush          (flush),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_pc4         (id_pc4),
        .id_instruction (id_instruction),
        .occupancy      (occupancy)
`ifdef PIPE_IF_ID_PERF_EN
        ,
        .stall_cycles   (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, let the edge pass, then apply that cycle's effect to the model
    task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                         input logic fl, input logic idr, input logic r);
        int pre_size;
        if_valid       = v;
        if_pc4         = pc;
        if_instruction = ins;
        flush          = fl;
        id_ready       = idr;
        rst            = r;
        pre_size       = exp_q.size();
        @(posedge clk);
        if (r) begin
            exp_q.delete();
            stall_exp = '0;
        end else if (fl) begin
            exp_q.delete();
        end else begin
            if (v && pre_size < 2) exp_q.push_back('{pc4: pc, ins: ins});
            if (v && pre_size >= 2) stall_exp = stall_exp + 32'd1;
        end
        #2;
    endtask

    task automatic idle(input logic idr);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, idr, 1'b0);
    endtask

    // Monitor: compare DUT against the model mid-cycle, retire consumed words
    always @(negedge clk) begin
        if (mon_en) begin
            int sz;
            sz = exp_q.size();
            check("occupancy", 32'(occupancy), 32'(sz));
            check("if_ready",  32'(if_ready),  32'(sz < 2));
            check("id_valid",  32'(id_valid),  32'(sz != 0));
            if (sz == 0) begin
                check("bubble_pc4", id_pc4, 32'h0);
                check("bubble_ins", id_instruction, 32'h0);
            end else begin
                check("head_pc4", id_pc4, exp_q[0].pc4);
                check("head_ins", id_instruction, exp_q[0].ins);
            end
`ifdef PIPE_IF_ID_PERF_EN
            check("stall_cycles", stall_cycles, stall_exp);
`endif
            if (!rst && !flush && id_ready && sz != 0) void'(exp_q.pop_front());
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
        mon_en = 1'b1;

        // Pass-through with one-cycle latency, then bubble
        cycle(1'b1, 32'h04, 32'h20080005, 1'b0, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Fill to full, third word held off, then drain in order
        cycle(1'b1, 32'h04, 32'hAAAA0001, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h08, 32'hAAAA0002, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h0C, 32'hAAAA0003, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h0C, 32'hAAAA0003, 1'b0, 1'b1, 1'b0);
        repeat (3) idle(1'b1);

        // Simultaneous push/pop at count=1 across pointer wrap
        cycle(1'b1, 32'h100, 32'hBBBB0000, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 7; i++) begin
            cycle(1'b1, 32'h100 + 32'(i * 4), 32'hBBBB0000 + 32'(i), 1'b0, 1'b1, 1'b0);
        end
        repeat (2) idle(1'b1);

        // Flush with a simultaneous push: the incoming word is dropped
        cycle(1'b1, 32'h20, 32'hCCCC0001, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h24, 32'hCCCC0002, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h40, 32'hDEAD0040, 1'b1, 1'b1, 1'b0);
        repeat (2) idle(1'b1);

        // Reset mid-operation while full and pushing
        cycle(1'b1, 32'h50, 32'hEEEE0001, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h54, 32'hEEEE0002, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h58, 32'hEEEE0003, 1'b0, 1'b0, 1'b1);
        idle(1'b0);

        // Hold full with fetch pending for 5 cycles, then flush
        cycle(1'b1, 32'h60, 32'hFFFF0001, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h64, 32'hFFFF0002, 1'b0, 1'b0, 1'b0);
        repeat (5) cycle(1'b1, 32'h68, 32'hFFFF0003, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h68, 32'hFFFF0003, 1'b1, 1'b0, 1'b0);
        repeat (2) idle(1'b0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic v, fl, idr, r;
            v   = ($urandom_range(0, 9) < 7);
            idr = ($urandom_range(0, 9) < 6);
            fl  = ($urandom_range(0, 99) < 5);
            r   = ($urandom_range(0, 199) == 0);
            cycle(v, $urandom, $urandom, fl, idr, r);
        end
        repeat (3) idle(1'b1);

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
